// File: rtl/key_event.sv
// key_event: turns a debounced key level into press / release / long-press /
// auto-repeat pulses, a held level and a modulo-256 press counter.
// Every output is registered. The key level has no handshake: in_i is
// sampled on every rising clk edge, and each pulse output is valid for
// exactly the one cycle in which it is high.
module key_event #(
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_i,
  input  logic       clr_i,
  output logic       press_o,
  output logic       release_o,
  output logic       long_press_o,
  output logic       rep_o,
  output logic       held_o,
  output logic [7:0] press_count_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Terminal hold-counter values. Both fit in CNT_W because the legal
  // range of each parameter tops out at 2^CNT_W.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             held_q, held_d;
  logic [7:0]       count_q, count_d;

  // Next-state, hold-counter and pulse decode. A release is checked first
  // so that it takes priority over long_press or rep at the terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    rep_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_i) begin
          state_d = PRESS;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESS: begin
        if (!in_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!in_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  // Press counter: clr wins over the old value but still counts a press
  // landing on the same edge.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = press_d ? 8'd1 : 8'd0;
    end else if (press_d) begin
      count_d = count_q + 8'd1;
    end
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  assign press_o       = press_q;
  assign release_o     = release_q;
  assign long_press_o  = long_q;
  assign rep_o         = rep_q;
  assign held_o        = held_q;
  assign press_count_o = count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed vectors for key_event with LONG_CYCLES=8 and
// REPEAT_CYCLES=4. The pulse bundle is {press, release, long_press, rep, held}.
module tb_key_event;

  logic       clk;
  logic       rst;
  logic       in_i;
  logic       clr_i;
  logic       press;
  logic       rel;
  logic       long_press;
  logic       rep;
  logic       held;
  logic [7:0] press_count;
  logic [1:0] state;

  int vec_cnt;
  int err_cnt;

  logic [4:0] exp_q[$];

  key_event #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_i         (in_i),
    .clr_i        (clr_i),
    .press_o      (press),
    .release_o    (rel),
    .long_press_o (long_press),
    .rep_o        (rep),
    .held_o       (held),
    .press_count_o(press_count),
    .state_o      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] pulses();
    return {press, rel, long_press, rep, held};
  endfunction

  // drive inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic in_v, input logic clr_v);
    in_i  = in_v;
    clr_i = clr_v;
    @(posedge clk);
    #1;
  endtask

  // push expected bundle, take the edge, compare against the popped entry
  task automatic step_exp(input string tag, input logic in_v, input logic [4:0] exp);
    logic [4:0] e;
    exp_q.push_back(exp);
    step(in_v, 1'b0);
    e = exp_q.pop_front();
    check(tag, 32'(pulses()), 32'(e));
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    in_i    = 1'b1;   // key already down during reset
    clr_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pulses", 32'(pulses()), 32'h0);
    check("reset_count", 32'(press_count), 32'h0);
    check("reset_state", 32'(state), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // short tap: first edge after reset sees in=1 and presses
    step_exp("tap_e0", 1'b1, 5'b10001);
    step_exp("tap_e1", 1'b1, 5'b00001);
    step_exp("tap_e2", 1'b1, 5'b00001);
    step_exp("tap_e3", 1'b0, 5'b01000);
    check("tap_count", 32'(press_count), 32'd1);
    step_exp("tap_idle", 1'b0, 5'b00000);

    // long hold: press@0 long@8 rep@12,16 release@20
    for (int i = 0; i <= 20; i++) begin
      logic [4:0] e;
      e = {(i == 0), (i == 20), (i == 8), (i == 12 || i == 16), (i < 20)};
      step_exp($sformatf("hold_e%0d", i), (i < 20), e);
    end
    step_exp("hold_after", 1'b0, 5'b00000);
    check("hold_count", 32'(press_count), 32'd2);

    // boundary: release at the edge where long_press would have fired
    for (int i = 0; i <= 8; i++) begin
      logic [4:0] e;
      e = {(i == 0), (i == 8), 1'b0, 1'b0, (i < 8)};
      step_exp($sformatf("bound_e%0d", i), (i < 8), e);
    end
    check("bound_count", 32'(press_count), 32'd3);
    check("bound_state", 32'(state), 32'h0);

    // clr alone, then 256 taps wrap back to zero
    step(1'b0, 1'b1);
    check("clr_alone", 32'(press_count), 32'd0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    check("wrap_count", 32'(press_count), 32'd0);

    // clr on the press edge keeps the press
    step(1'b1, 1'b1);
    check("clr_press_count", 32'(press_count), 32'd1);
    check("clr_press_pulse", 32'(pulses()), 32'b10001);
    // clr while held leaves the FSM alone
    step(1'b1, 1'b1);
    check("clr_held_count", 32'(press_count), 32'd0);
    check("clr_held_pulse", 32'(pulses()), 32'b00001);
    step(1'b0, 1'b0);
    check("clr_rel_pulse", 32'(pulses()), 32'b01000);
    step(1'b0, 1'b1);
    check("clr_idle_count", 32'(press_count), 32'd0);

    // async reset in the middle of a hold, key kept down
    for (int i = 0; i <= 10; i++) step(1'b1, 1'b0);
    check("pre_rst_state", 32'(state), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_pulses", 32'(pulses()), 32'h0);
    check("async_state", 32'(state), 32'h0);
    check("async_count", 32'(press_count), 32'h0);
    #2 rst = 1'b0;
    step(1'b1, 1'b0);
    check("post_rst_pulse", 32'(pulses()), 32'b10001);
    check("post_rst_count", 32'(press_count), 32'd1);
    step(1'b0, 1'b0);
    check("post_rst_rel", 32'(pulses()), 32'b01000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
